// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the raster generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axisTimingT;

  typedef struct packed {
    axisTimingT h;
    axisTimingT v;
  } modeT;

  localparam modeT MODE640X480 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
  localparam modeT MODE800X600 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int x = n - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int syncStart(input int active, input int fp);
    return active + fp;
  endfunction

  // Exclusive end of the sync region.
  function automatic int syncEnd(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Clock-enable divider: pix_en is high in the cycle the phase counter sits at CLK_DIV-1.
module pixel_tick_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4
)(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic pix_en
);

  localparam int DW = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (reset)   div <= '0;
    else if (en) div <= (div == LAST) ? '0 : div + 1'b1;
  end

  // Gated combinationally so a freeze or reset suppresses the tick in the same cycle.
  assign pix_en = en & ~reset & (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on the system clock with a pixel-rate clock enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   CW       = 12,
  parameter int   H_ACTIVE = int'(MODE640X480.h.active),
  parameter int   H_FP     = int'(MODE640X480.h.fp),
  parameter int   H_SYNC   = int'(MODE640X480.h.sync),
  parameter int   H_BP     = int'(MODE640X480.h.bp),
  parameter int   V_ACTIVE = int'(MODE640X480.v.active),
  parameter int   V_FP     = int'(MODE640X480.v.fp),
  parameter int   V_SYNC   = int'(MODE640X480.v.sync),
  parameter int   V_BP     = int'(MODE640X480.v.bp),
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pix_en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = syncStart(H_ACTIVE, H_FP);
  localparam int HS_END   = syncEnd(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_START = syncStart(V_ACTIVE, V_FP);
  localparam int VS_END   = syncEnd(V_ACTIVE, V_FP, V_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  if (CLK_DIV < 1 || H_SYNC == 0 || V_SYNC == 0 ||
      longint'(H_TOTAL) > (longint'(1) << CW) ||
      longint'(V_TOTAL) > (longint'(1) << CW)) begin : gCfgCheck
    $error("vga_timing_gen: invalid timing configuration");
  end

  function automatic logic inRange(input logic [CW-1:0] c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

  logic          tick;
  logic [CW-1:0] hNext, vNext;
  logic          lineStartQ, frameStartQ;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) uTickDiv (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .pix_en (tick)
  );

  always_comb begin
    hNext = h_count + 1'b1;
    vNext = v_count;
    if (h_count == H_LAST) begin
      hNext = '0;
      vNext = (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end
  end

  // Everything decodes from the next-state counts so sync, de and pulses line up with the coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count     <= H_LAST;
      v_count     <= V_LAST;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      lineStartQ  <= 1'b0;
      frameStartQ <= 1'b0;
    end else if (tick) begin
      h_count     <= hNext;
      v_count     <= vNext;
      hs          <= inRange(hNext, HS_START, HS_END) ? HS_POL : ~HS_POL;
      vs          <= inRange(vNext, VS_START, VS_END) ? VS_POL : ~VS_POL;
      de          <= (int'(hNext) < H_ACTIVE) && (int'(vNext) < V_ACTIVE);
      lineStartQ  <= (hNext == '0);
      frameStartQ <= (hNext == '0) && (vNext == '0);
    end else begin
      lineStartQ  <= 1'b0;
      frameStartQ <= 1'b0;
    end
  end

  assign pix_en      = tick;
  assign line_start  = lineStartQ & en;
  assign frame_start = frameStartQ & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small raster (16x8 totals, CLK_DIV=2).
module tb_vga_timing_gen;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;

  logic          pixEn, hs, vs, de, ls, fs;
  logic [CW-1:0] h, v;
  logic          pixEn2, hs2, vs2, de2, ls2, fs2;
  logic [CW-1:0] h2, v2;

  int testCnt = 0;
  int failCnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(2), .CW(CW),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pix_en(pixEn), .hs(hs), .vs(vs), .de(de),
    .h_count(h), .v_count(v), .line_start(ls), .frame_start(fs)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .CW(CW),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dutPol (
    .clk(clk), .reset(reset), .en(en), .pix_en(pixEn2), .hs(hs2), .vs(vs2), .de(de2),
    .h_count(h2), .v_count(v2), .line_start(ls2), .frame_start(fs2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkResetState(input string tag);
    chk({tag, "_h"}, 32'(h), 32'd15);
    chk({tag, "_v"}, 32'(v), 32'd7);
    chk({tag, "_hs"}, 32'(hs), 32'd1);
    chk({tag, "_vs"}, 32'(vs), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_pulses"}, 32'({pixEn, ls, fs}), 32'd0);
  endtask

  task automatic chkRelease(input string tag);
    reset = 1'b0;
    #1 chk({tag, "_c1_pix"}, 32'(pixEn), 32'd0);
    @(negedge clk);
    chk({tag, "_c2_pix"}, 32'(pixEn), 32'd1);
    chk({tag, "_c2_h"}, 32'(h), 32'd15);
    @(negedge clk);
    chk({tag, "_h0"}, 32'(h), 32'd0);
    chk({tag, "_v0"}, 32'(v), 32'd0);
    chk({tag, "_de"}, 32'(de), 32'd1);
    chk({tag, "_ls"}, 32'(ls), 32'd1);
    chk({tag, "_fs"}, 32'(fs), 32'd1);
    chk({tag, "_pix"}, 32'(pixEn), 32'd0);
  endtask

  initial begin
    int hsLow, vsLow, lsCnt, fsCnt, deTicks, pixCnt, decBad, vsBad, polBad;
    int lsPos0, lsPos1, fsPos0, fsPos1, holdBad;
    logic prevVs, hsH, vsH, deH, found;
    logic [CW-1:0] vH;

    // Reset state, both polarities
    repeat (3) @(negedge clk);
    chkResetState("rst");
    chk("rst_hs_pol1", 32'(hs2), 32'd0);
    chk("rst_vs_pol1", 32'(vs2), 32'd0);

    // Reset release: first pix_en in cycle 2, next edge lands on (0,0)
    chkRelease("rel");

    // Two full frames of steady-state raster starting at the frame-start sample
    hsLow = 0; vsLow = 0; lsCnt = 0; fsCnt = 0; deTicks = 0; pixCnt = 0;
    decBad = 0; vsBad = 0; polBad = 0;
    lsPos0 = -1; lsPos1 = -1; fsPos0 = -1; fsPos1 = -1;
    prevVs = vs;
    for (int i = 0; i < 512; i++) begin
      if (!hs) hsLow++;
      if (!vs) vsLow++;
      if (pixEn) pixCnt++;
      if (de && pixEn) deTicks++;
      if (ls) begin
        lsCnt++;
        if (lsPos0 < 0) lsPos0 = i; else if (lsPos1 < 0) lsPos1 = i;
      end
      if (fs) begin
        fsCnt++;
        if (fsPos0 < 0) fsPos0 = i; else if (fsPos1 < 0) fsPos1 = i;
      end
      if (hs !== !(h >= 10 && h < 13)) decBad++;
      if (vs !== !(v >= 5 && v < 7)) decBad++;
      if (de !== (h < 8 && v < 4)) decBad++;
      if (vs !== prevVs && h != 0) vsBad++;
      if (hs2 !== ~hs || vs2 !== ~vs) polBad++;
      prevVs = vs;
      @(negedge clk);
    end
    chk("ss_hs_low_clks", 32'(hsLow), 32'd96);
    chk("ss_vs_low_clks", 32'(vsLow), 32'd128);
    chk("ss_line_starts", 32'(lsCnt), 32'd16);
    chk("ss_line_period", 32'(lsPos1 - lsPos0), 32'd32);
    chk("ss_frame_starts", 32'(fsCnt), 32'd2);
    chk("ss_frame_period", 32'(fsPos1 - fsPos0), 32'd256);
    chk("ss_de_ticks", 32'(deTicks), 32'd64);
    chk("ss_pix_ticks", 32'(pixCnt), 32'd256);
    chk("ss_decode", 32'(decBad), 32'd0);
    chk("ss_vs_at_h0_only", 32'(vsBad), 32'd0);
    chk("ss_inverted_pol", 32'(polBad), 32'd0);

    // Freeze with en=0 at h=5, just before its tick
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (h == 5 && pixEn) found = 1'b1;
      else @(negedge clk);
    end
    chk("en_wait_h5", 32'(found), 32'd1);
    hsH = hs; vsH = vs; deH = de; vH = v;
    en = 1'b0;
    #1 chk("en_off_pix", 32'(pixEn), 32'd0);
    holdBad = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (h != 5 || v != vH || hs !== hsH || vs !== vsH || de !== deH) holdBad++;
      if (pixEn || ls || fs) holdBad++;
    end
    chk("en_off_hold", 32'(holdBad), 32'd0);
    chk("en_off_h", 32'(h), 32'd5);
    en = 1'b1;
    #1 chk("en_resume_pix", 32'(pixEn), 32'd1);
    @(negedge clk);
    chk("en_resume_h", 32'(h), 32'd6);
    chk("en_resume_v", 32'(v), 32'(vH));

    // Reset mid-frame at (3,9) with en low and divider mid-phase: reset wins
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (v == 3 && h == 9 && pixEn) found = 1'b1;
      else @(negedge clk);
    end
    chk("mid_wait_v3h9", 32'(found), 32'd1);
    reset = 1'b1;
    en = 1'b0;
    #1 chk("mid_rst_pix", 32'(pixEn), 32'd0);
    @(negedge clk);
    chkResetState("mid_rst_en0");
    en = 1'b1;
    @(negedge clk);
    chkResetState("mid_rst_en1");

    // Restart must match the power-up release
    chkRelease("rel2");

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
